// File: rtl/mem_io_pkg.sv
// Shared constants and the address-region enum for the data-memory / memory-mapped I/O stage.
package mem_io_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] ADDR_IN0  = 32'h0000_0080;
  localparam logic [WORD_W-1:0] ADDR_IN1  = 32'h0000_0084;
  localparam logic [WORD_W-1:0] ADDR_CNT  = 32'h0000_0088;
  localparam logic [WORD_W-1:0] ADDR_OUT0 = 32'h0000_00C0;
  localparam logic [WORD_W-1:0] ADDR_OUT1 = 32'h0000_00C4;
  localparam logic [WORD_W-1:0] RAM_LIMIT = 32'h0000_0080;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_IN0,
    REG_IN1,
    REG_OUT0,
    REG_OUT1,
    REG_CNT,
    REG_NONE
  } region_t;

endpackage

// File: rtl/mem_io_unit_sync_chain.sv
// Multi-bit flop-chain synchronizer for asynchronous inputs; output lags input by STAGES edges.
module sync_chain #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/mem_io_unit.sv
// Data RAM plus memory-mapped input/output ports; combinational reads, stores commit on the clock edge.
// MEM_IO_CYCLE_COUNTER_EN adds a read/write free-running cycle counter at 0x88.
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int RAM_WORDS   = 32,
  parameter int IN_WIDTH    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WORD_W-1:0]   addr,
  input  logic [WORD_W-1:0]   wdata,
  input  logic                we,
  output logic [WORD_W-1:0]   rdata,
  input  logic [IN_WIDTH-1:0] in_port0,
  input  logic [IN_WIDTH-1:0] in_port1,
  output logic [WORD_W-1:0]   out_port0,
  output logic [WORD_W-1:0]   out_port1,
  output logic                addr_err
);

  localparam logic [5:0] RAM_WORDS_L = 6'(RAM_WORDS);

  logic [WORD_W-1:0]   r_ram [RAM_WORDS];
  logic [WORD_W-1:0]   r_out0;
  logic [WORD_W-1:0]   r_out1;
  logic [IN_WIDTH-1:0] w_in0;
  logic [IN_WIDTH-1:0] w_in1;
  logic                w_aligned;
  logic                w_we_ok;
  region_t             w_region;

  sync_chain #(.WIDTH(IN_WIDTH), .STAGES(SYNC_STAGES)) u_sync0 (
    .clock (clock),
    .reset (reset),
    .d     (in_port0),
    .q     (w_in0)
  );

  sync_chain #(.WIDTH(IN_WIDTH), .STAGES(SYNC_STAGES)) u_sync1 (
    .clock (clock),
    .reset (reset),
    .d     (in_port1),
    .q     (w_in1)
  );

  always_comb begin
    w_aligned = (addr[31:8] == '0) && (addr[1:0] == 2'b00);
    w_region  = REG_NONE;
    if (w_aligned) begin
      if (addr[7:0] < RAM_LIMIT[7:0]) begin
        if ({1'b0, addr[6:2]} < RAM_WORDS_L) w_region = REG_RAM;
      end else begin
        case (addr[7:0])
          ADDR_IN0[7:0]:  w_region = REG_IN0;
          ADDR_IN1[7:0]:  w_region = REG_IN1;
          ADDR_OUT0[7:0]: w_region = REG_OUT0;
          ADDR_OUT1[7:0]: w_region = REG_OUT1;
`ifdef MEM_IO_CYCLE_COUNTER_EN
          ADDR_CNT[7:0]:  w_region = REG_CNT;
`endif
          default:        w_region = REG_NONE;
        endcase
      end
    end
  end

  // Input ports are read-only: a store there is an error, not a silent no-op.
  assign addr_err = (w_region == REG_NONE) ||
                    (we && ((w_region == REG_IN0) || (w_region == REG_IN1)));
  assign w_we_ok  = we && !addr_err;

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [WORD_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_we_ok && (w_region == REG_CNT)) begin
      r_cnt <= wdata;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (w_region)
      REG_RAM:  rdata = r_ram[addr[6:2]];
      REG_IN0:  rdata = WORD_W'(w_in0);
      REG_IN1:  rdata = WORD_W'(w_in1);
      REG_OUT0: rdata = r_out0;
      REG_OUT1: rdata = r_out1;
`ifdef MEM_IO_CYCLE_COUNTER_EN
      REG_CNT:  rdata = r_cnt;
`endif
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) r_ram[i] <= '0;
    end else if (w_we_ok && (w_region == REG_RAM)) begin
      r_ram[addr[6:2]] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out0 <= '0;
      r_out1 <= '0;
    end else if (w_we_ok) begin
      if (w_region == REG_OUT0) r_out0 <= wdata;
      if (w_region == REG_OUT1) r_out1 <= wdata;
    end
  end

  assign out_port0 = r_out0;
  assign out_port1 = r_out1;

endmodule

// File: tb/tb_mem_io_unit.sv
// Self-checking bench for mem_io_unit: vector table plus hand-written synchronizer, counter and reset sequences.
module tb_mem_io_unit;

  localparam int IN_W = 10;
  localparam int SYNC = 2;

  logic            clock;
  logic            reset;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            we;
  logic [31:0]     rdata;
  logic [IN_W-1:0] in_port0;
  logic [IN_W-1:0] in_port1;
  logic [31:0]     out_port0;
  logic [31:0]     out_port1;
  logic            addr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_exp[$];
  string       sb_name[$];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  mem_io_unit #(.RAM_WORDS(32), .IN_WIDTH(IN_W), .SYNC_STAGES(SYNC)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .addr_err  (addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [31:0] exp);
    sb_exp.push_back(exp);
    sb_name.push_back(nm);
  endtask

  task automatic sb_pop_cmp();
    if (sb_exp.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue required an entry");
    end else begin
      chk(sb_name.pop_front(), rdata, sb_exp.pop_front());
    end
  endtask

  task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    sb_push(nm, exp);
    #1;
    sb_pop_cmp();
  endtask

  initial begin
    reset    = 1'b1;
    addr     = 32'h0;
    wdata    = 32'h0;
    we       = 1'b0;
    in_port0 = '0;
    in_port1 = '0;

    vecs.push_back('{"ram10_wr_old",   32'h10,       32'hDEADBEEF, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{"ram7c_wr_old",   32'h7C,       32'h12345678, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{"ram10_rd",       32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{"ram7c_rd",       32'h7C,       32'h0,        1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{"ram14_rd",       32'h14,       32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{"misalign11",     32'h11,       32'h0,        1'b0, 32'h0,        1'b1});
    vecs.push_back('{"hiaddr104_wr",   32'h104,      32'hAAAA5555, 1'b1, 32'h0,        1'b1});
    vecs.push_back('{"ram04_noalias",  32'h04,       32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{"in0_wr_err",     32'h80,       32'hFFFFFFFF, 1'b1, 32'h0,        1'b1});
    vecs.push_back('{"in0_rd",         32'h80,       32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{"out0_wr_old",    32'hC0,       32'h0000FFFF, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{"out0_rd",        32'hC0,       32'h0,        1'b0, 32'h0000FFFF, 1'b0});
    vecs.push_back('{"out1_rd",        32'hC4,       32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{"unmapped90",     32'h90,       32'h0,        1'b0, 32'h0,        1'b1});
    vecs.push_back('{"unmappedC8_wr",  32'hC8,       32'h77,       1'b1, 32'h0,        1'b1});
    vecs.push_back('{"hi_c0_alias",    32'h1000_00C0,32'h0,        1'b0, 32'h0,        1'b1});
    vecs.push_back('{"in1_rd",         32'h84,       32'h0,        1'b0, 32'h0,        1'b0});

    // Asynchronous reset: outputs visible before any clock edge.
    #1;
    chk("rst_out0", out_port0, 32'h0);
    chk("rst_out1", out_port1, 32'h0);
    rd_check("rst_ram00", 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      addr  = vecs[i].a;
      wdata = vecs[i].d;
      we    = vecs[i].w;
      sb_push(vecs[i].name, vecs[i].exp_rd);
      #1;
      sb_pop_cmp();
      chk({vecs[i].name, "_err"}, {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
    end
    @(negedge clock);
    we = 1'b0;
    #1;
    chk("out0_port", out_port0, 32'h0000FFFF);
    chk("out1_port", out_port1, 32'h0);
    rd_check("ram_after_104", 32'h04, 32'h0);

    // Input synchronizer latency on in_port0.
    @(negedge clock);
    in_port0 = 10'h2A5;
    rd_check("sync0_e0", 32'h80, 32'h0);
    for (int k = 1; k <= SYNC; k++) begin
      @(posedge clock);
      #1;
      sb_push($sformatf("sync0_e%0d", k), (k < SYNC) ? 32'h0 : 32'h0000_02A5);
      sb_pop_cmp();
    end

    // Store to read-only port is rejected and flagged.
    @(negedge clock);
    addr = 32'h80; wdata = 32'h0; we = 1'b1;
    #1;
    chk("in0_wr2_err", {31'b0, addr_err}, 32'h1);
    @(negedge clock);
    rd_check("in0_unchanged", 32'h80, 32'h0000_02A5);

    @(negedge clock);
    in_port1 = 10'h155;
    repeat (SYNC) @(posedge clock);
    #1;
    rd_check("sync1", 32'h84, 32'h0000_0155);

`ifdef MEM_IO_CYCLE_COUNTER_EN
    @(negedge clock);
    addr = 32'h88; wdata = 32'hFFFFFFFE; we = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
    rd_check("cnt_load", 32'h88, 32'hFFFFFFFE);
    @(posedge clock);
    #1;
    rd_check("cnt_max", 32'h88, 32'hFFFFFFFF);
    @(posedge clock);
    #1;
    rd_check("cnt_wrap", 32'h88, 32'h0);
`else
    @(negedge clock);
    rd_check("cnt_absent_rd", 32'h88, 32'h0);
    chk("cnt_absent_err", {31'b0, addr_err}, 32'h1);
`endif

    @(negedge clock);
    addr = 32'hC4; wdata = 32'h5; we = 1'b1;
    @(negedge clock);
    we = 1'b0;
    #1;
    chk("out1_set", out_port1, 32'h5);

    // Mid-run reset with a pending store to out_port0; reset must win.
    @(negedge clock);
    addr = 32'hC0; wdata = 32'h1234; we = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_out0", out_port0, 32'h0);
    chk("mrst_out1", out_port1, 32'h0);
    rd_check("mrst_ram10", 32'h10, 32'h0);
    rd_check("mrst_ram7c", 32'h7C, 32'h0);
    rd_check("mrst_in0", 32'h80, 32'h0);
`ifdef MEM_IO_CYCLE_COUNTER_EN
    rd_check("mrst_cnt", 32'h88, 32'h0);
`endif
    @(negedge clock);
    reset = 1'b0;
    rd_check("post_rst_out0", 32'hC0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
